// File: rtl/sal_req_pkg.sv
// Shared types and DRAM address decode for the SAL request bridge.
// The bridge's width parameters default to these constants and must stay equal to them.
package sal_req_pkg;

  localparam int SAL_ID_W   = 4;
  localparam int SAL_ADDR_W = 32;
  localparam int SAL_LEN_W  = 4;
  localparam int SAL_CA_W   = 10;
  localparam int SAL_RA_W   = 14;

  typedef struct packed {
    logic [SAL_ID_W-1:0]   id;
    logic [SAL_ADDR_W-1:0] addr;
    logic [SAL_LEN_W-1:0]  len;
  } req_entry_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

  // 32-byte granularity: a[4:0] dropped, column keeps two zero LSBs
  function automatic logic [SAL_CA_W-1:0] get_dram_ca(input logic [SAL_ADDR_W-1:0] a);
    return {a[SAL_CA_W+2:5], 2'b00};
  endfunction

  function automatic logic [SAL_RA_W-1:0] get_dram_ra(input logic [SAL_ADDR_W-1:0] a);
    return a[SAL_CA_W+SAL_RA_W+2:SAL_CA_W+3];
  endfunction

endpackage

// File: rtl/sal_req_fifo.sv
// DEPTH-entry synchronous FIFO of request entries with registered occupancy count.
module sal_req_fifo
  import sal_req_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  req_entry_t din,
  input  logic       pop,
  output req_entry_t dout,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  req_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers and count define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sal_axi_req_bridge.sv
// AW/AR request front end: per-channel FIFOs, round-robin arbiter, DRAM
// address decode and a single output register slice toward the controller.
module sal_axi_req_bridge
  import sal_req_pkg::*;
#(
  parameter int ID_W   = SAL_ID_W,
  parameter int ADDR_W = SAL_ADDR_W,
  parameter int LEN_W  = SAL_LEN_W,
  parameter int CA_W   = SAL_CA_W,
  parameter int RA_W   = SAL_RA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ID_W-1:0]   aw_id,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [LEN_W-1:0]  aw_len,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [LEN_W-1:0]  ar_len,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ID_W-1:0]   req_id,
  output logic [RA_W-1:0]   req_ra,
  output logic [CA_W-1:0]   req_ca,
  output logic              req_wr,
  output logic [LEN_W-1:0]  req_len
);

  req_entry_t aw_din, ar_din, aw_dout, ar_dout, sel_entry;
  logic       aw_full, aw_empty, ar_full, ar_empty;
  logic       aw_pop, ar_pop, load;
  logic       grant_vld;
  grant_t     grant_sel, last_grant;

  logic              req_valid_p1;
  logic [ID_W-1:0]   req_id_p1;
  logic [RA_W-1:0]   req_ra_p1;
  logic [CA_W-1:0]   req_ca_p1;
  logic              req_wr_p1;
  logic [LEN_W-1:0]  req_len_p1;

  assign aw_ready = !aw_full;
  assign ar_ready = !ar_full;
  assign aw_din   = '{id: aw_id, addr: aw_addr, len: aw_len};
  assign ar_din   = '{id: ar_id, addr: ar_addr, len: ar_len};

  sal_req_fifo #(.DEPTH(DEPTH)) u_aw_fifo (
    .clk(clk), .rst_n(rst_n), .push(aw_valid && aw_ready), .din(aw_din),
    .pop(aw_pop), .dout(aw_dout), .full(aw_full), .empty(aw_empty)
  );

  sal_req_fifo #(.DEPTH(DEPTH)) u_ar_fifo (
    .clk(clk), .rst_n(rst_n), .push(ar_valid && ar_ready), .din(ar_din),
    .pop(ar_pop), .dout(ar_dout), .full(ar_full), .empty(ar_empty)
  );

  // Stage p0 -> p1: the slice may load when empty or being drained this cycle
  assign load = !req_valid_p1 || req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant <= GRANT_RD;
    else if (grant_vld) last_grant <= grant_sel;
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_sel = GRANT_RD;
    if (load) begin
      if (!aw_empty && !ar_empty) begin
        grant_vld = 1'b1;
        grant_sel = (last_grant == GRANT_RD) ? GRANT_WR : GRANT_RD;
      end else if (!aw_empty) begin
        grant_vld = 1'b1;
        grant_sel = GRANT_WR;
      end else if (!ar_empty) begin
        grant_vld = 1'b1;
        grant_sel = GRANT_RD;
      end
    end
  end

  always_comb begin
    aw_pop    = grant_vld && (grant_sel == GRANT_WR);
    ar_pop    = grant_vld && (grant_sel == GRANT_RD);
    sel_entry = (grant_sel == GRANT_WR) ? aw_dout : ar_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_p1 <= 1'b0;
      req_id_p1    <= '0;
      req_ra_p1    <= '0;
      req_ca_p1    <= '0;
      req_wr_p1    <= 1'b0;
      req_len_p1   <= '0;
    end else if (load) begin
      req_valid_p1 <= grant_vld;
      if (grant_vld) begin
        req_id_p1  <= sel_entry.id;
        req_ra_p1  <= get_dram_ra(sel_entry.addr);
        req_ca_p1  <= get_dram_ca(sel_entry.addr);
        req_wr_p1  <= (grant_sel == GRANT_WR);
        req_len_p1 <= sel_entry.len;
      end
    end
  end

  assign req_valid = req_valid_p1;
  assign req_id    = req_id_p1;
  assign req_ra    = req_ra_p1;
  assign req_ca    = req_ca_p1;
  assign req_wr    = req_wr_p1;
  assign req_len   = req_len_p1;

endmodule

// File: tb/tb_sal_axi_req_bridge.sv
// Scoreboard bench for sal_axi_req_bridge: input handshakes queue expected
// requests per channel, output handshakes pop and compare them.
module tb_sal_axi_req_bridge;
  import sal_req_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aw_valid, aw_ready, ar_valid, ar_ready;
  logic [3:0]  aw_id, ar_id, aw_len, ar_len;
  logic [31:0] aw_addr, ar_addr;
  logic        req_valid, req_ready, req_wr;
  logic [3:0]  req_id, req_len;
  logic [13:0] req_ra;
  logic [9:0]  req_ca;

  typedef struct packed {
    logic [3:0]  id;
    logic [13:0] ra;
    logic [9:0]  ca;
    logic        wr;
    logic [3:0]  len;
  } exp_t;

  exp_t exp_wr_q[$];
  exp_t exp_rd_q[$];
  bit   log_wr[$];
  int   log_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   prev_stall = 0;
  exp_t prev_out;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sal_axi_req_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_ra(req_ra),
    .req_ca(req_ca), .req_wr(req_wr), .req_len(req_len)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic req_entry_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    return '{id: id, addr: addr, len: len};
  endfunction

  // Scoreboard: inputs push, outputs pop; sampled on the falling edge
  always @(negedge clk) begin
    exp_t cur, e;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (aw_valid && aw_ready)
        exp_wr_q.push_back('{id: aw_id, ra: get_dram_ra(aw_addr), ca: get_dram_ca(aw_addr), wr: 1'b1, len: aw_len});
      if (ar_valid && ar_ready)
        exp_rd_q.push_back('{id: ar_id, ra: get_dram_ra(ar_addr), ca: get_dram_ca(ar_addr), wr: 1'b0, len: ar_len});
      cur = '{id: req_id, ra: req_ra, ca: req_ca, wr: req_wr, len: req_len};
      if (prev_stall) begin
        chk("stall_valid", req_valid, 1'b1);
        chk("stall_hold", cur, prev_out);
      end
      if (req_valid && req_ready) begin
        if (req_wr ? exp_wr_q.size() == 0 : exp_rd_q.size() == 0) begin
          chk("sb_unexpected", cur, '0);
        end else begin
          e = req_wr ? exp_wr_q.pop_front() : exp_rd_q.pop_front();
          chk("sb_req", cur, e);
        end
        log_wr.push_back(req_wr);
        log_cyc.push_back(cyc);
      end
      prev_stall = req_valid && !req_ready;
      prev_out   = cur;
    end
  end

  // Hold each requested valid until its handshake, bounded
  task automatic drive(input bit do_aw, input req_entry_t awe, input bit do_ar, input req_entry_t are);
    bit aw_done, ar_done;
    int n = 0;
    aw_valid = do_aw; aw_id = awe.id; aw_addr = awe.addr; aw_len = awe.len;
    ar_valid = do_ar; ar_id = are.id; ar_addr = are.addr; ar_len = are.len;
    aw_done = !do_aw;
    ar_done = !do_ar;
    while (!(aw_done && ar_done) && n < 50) begin
      @(negedge clk);
      if (aw_valid && aw_ready) aw_done = 1;
      if (ar_valid && ar_ready) ar_done = 1;
      @(posedge clk); #1;
      if (aw_done) aw_valid = 0;
      if (ar_done) ar_valid = 0;
      n++;
    end
    chk("drive_timeout", n < 50, 1'b1);
    aw_valid = 0;
    ar_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || req_valid) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", n < 40, 1'b1);
  endtask

  task automatic send_chk(input bit is_wr, input logic [31:0] addr, input logic [13:0] ra, input logic [9:0] ca);
    int n = 0;
    if (is_wr) drive(1, mk(4'h9, addr, 4'h2), 0, '0);
    else       drive(0, '0, 1, mk(4'h9, addr, 4'h2));
    while (!req_valid && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    chk("dec_valid", req_valid, 1'b1);
    chk("dec_ra", req_ra, ra);
    chk("dec_ca", req_ca, ca);
    chk("dec_wr", req_wr, is_wr);
    wait_idle();
  endtask

  initial begin
    rst_n = 0; aw_valid = 0; ar_valid = 0; req_ready = 0;
    aw_id = 0; aw_addr = 0; aw_len = 0; ar_id = 0; ar_addr = 0; ar_len = 0;
    #23;
    chk("rst_aw_ready", aw_ready, 1'b1);
    chk("rst_ar_ready", ar_ready, 1'b1);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_req_fields", {req_id, req_ra, req_ca, req_wr, req_len}, '0);
    rst_n = 1;
    @(posedge clk); #1;

    // single write, one-edge latency
    req_ready = 1;
    drive(1, mk(4'h0, 32'h20, 4'h1), 0, '0);
    chk("lat_not_yet", req_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_valid", req_valid, 1'b1);
    chk("t1_ra", req_ra, 14'd0);
    chk("t1_ca", req_ca, 10'd4);
    chk("t1_wr", req_wr, 1'b1);
    chk("t1_len", req_len, 4'd1);
    wait_idle();

    // a lone read returns the arbiter to last_grant = READ
    drive(0, '0, 1, mk(4'h3, 32'h60, 4'h0));
    wait_idle();

    // simultaneous AW/AR: write wins the tie
    drive(1, mk(4'h1, 32'h0, 4'h0), 1, mk(4'h2, 32'h40, 4'h3));
    @(posedge clk); #1;
    chk("tie1_wr", req_wr, 1'b1);
    chk("tie1_ca", req_ca, 10'd0);
    chk("tie1_id", req_id, 4'd1);
    @(posedge clk); #1;
    chk("tie2_wr", req_wr, 1'b0);
    chk("tie2_ca", req_ca, 10'd8);
    chk("tie2_id", req_id, 4'd2);
    wait_idle();

    // backpressure: 4 FIFO entries + 1 output slice, then drain
    req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, mk(4'(i + 4), 32'h100 + 32'(i) * 32'h20, 4'(i)), 0, '0);
      if (i == 3) chk("bp_ready_after4", aw_ready, 1'b1);
    end
    chk("bp_ready_after5", aw_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_head_id", req_id, 4'd4);
    chk("bp_head_valid", req_valid, 1'b1);
    req_ready = 1;
    wait_idle();
    chk("bp_ready_back", aw_ready, 1'b1);

    // continuous streams: alternate, one per cycle
    log_wr.delete();
    log_cyc.delete();
    for (int i = 0; i < 6; i++)
      drive(1, mk(4'(i), 32'h1000 + 32'(i) * 32'h20, 4'h1), 1, mk(4'(i + 8), 32'h2000 + 32'(i) * 32'h20, 4'h2));
    wait_idle();
    chk("stream_count", 32'(log_wr.size()), 32'd12);
    for (int i = 1; i < log_wr.size(); i++) begin
      chk("stream_alt", log_wr[i] ^ log_wr[i-1], 1'b1);
      chk("stream_rate", 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
    end

    // decode boundaries
    send_chk(1, 32'h0000_8000, 14'd4, 10'd0);
    send_chk(0, 32'h0000_001F, 14'd0, 10'd0);
    send_chk(1, 32'h0000_2000, 14'd1, 10'd0);
    send_chk(0, 32'hF800_2020, 14'd1, 10'd4);
    send_chk(1, 32'h0000_3FE0, 14'd1, 10'h3FC);

    // asynchronous reset with work in flight
    req_ready = 0;
    drive(1, mk(4'hA, 32'h40, 4'h1), 1, mk(4'hB, 32'h80, 4'h1));
    drive(1, mk(4'hC, 32'hC0, 4'h1), 1, mk(4'hD, 32'h100, 4'h1));
    drive(1, mk(4'hE, 32'h140, 4'h1), 0, '0);
    chk("pre_rst_valid", req_valid, 1'b1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_req_valid", req_valid, 1'b0);
    chk("arst_aw_ready", aw_ready, 1'b1);
    chk("arst_ar_ready", ar_ready, 1'b1);
    exp_wr_q.delete();
    exp_rd_q.delete();
    @(posedge clk); #2;
    rst_n = 1;
    req_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", req_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
